// File: rtl/move_pkg.sv
// Shared types and keycode constants for the sprite move scheduler.
// Optional KEY_REPEAT_EN enables held-key auto-repeat in move_scheduler.
package move_pkg;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  localparam logic [15:0] KEY_W     = 16'h001A;
  localparam logic [15:0] KEY_S     = 16'h0016;
  localparam logic [15:0] KEY_A     = 16'h0004;
  localparam logic [15:0] KEY_D     = 16'h0007;
  localparam logic [15:0] KEY_SPACE = 16'h002C;

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous command queue of move directions.
// Flush has priority over push and pop.
module cmd_fifo
  import move_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  dir_t                     din,
  output dir_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  dir_t            mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            wr_en;
  logic            rd_en;

  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr_en = push && !full && !flush;
  assign rd_en = pop && !empty && !flush;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Keycode-driven sprite move scheduler with boundary blocking.
// Define KEY_REPEAT_EN to re-push held movement keys periodically.
module move_scheduler
  import move_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int STEP            = 1,
  parameter int FRAMES_PER_MOVE = 8,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 639,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 479,
`ifdef KEY_REPEAT_EN
  parameter int REPEAT_FRAMES   = 16,
`endif
  parameter int SIZE            = 4
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          frame_tick,
  input  logic [15:0]                   keycode,
  input  logic [9:0]                    pos_x,
  input  logic [9:0]                    pos_y,
  output logic [9:0]                    Motion_X,
  output logic [9:0]                    Motion_Y,
  output logic                          motion_valid,
  output logic                          busy,
  output logic                          blocked,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_count
);

  localparam int FW = $clog2(FRAMES_PER_MOVE + 1);
  localparam logic [9:0] STEP_P = 10'(STEP);
  localparam logic [9:0] STEP_N = 10'(-STEP);

  logic [15:0]   prev_key;
  logic          key_chg;
  logic          is_move;
  logic          key_flush;
  logic          push;
  logic          pop;
  logic          empty;
  logic          hit;
  dir_t          kdir;
  dir_t          head;
  dir_t          cur_dir;
  state_t        state;
  logic [FW-1:0] frame_cnt;
  logic [10:0]   px;
  logic [10:0]   py;

  assign key_chg   = keycode != prev_key;
  assign key_flush = key_chg && (keycode == KEY_SPACE);
  assign pop       = state == LOAD;
  assign px        = {1'b0, pos_x};
  assign py        = {1'b0, pos_y};

  always_comb begin
    is_move = 1'b0;
    kdir    = DIR_UP;
    unique case (1'b1)
      (keycode == KEY_W): begin is_move = 1'b1; kdir = DIR_UP;    end
      (keycode == KEY_S): begin is_move = 1'b1; kdir = DIR_DOWN;  end
      (keycode == KEY_A): begin is_move = 1'b1; kdir = DIR_LEFT;  end
      (keycode == KEY_D): begin is_move = 1'b1; kdir = DIR_RIGHT; end
      default: ;
    endcase
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES);
  logic [RW-1:0] rpt_cnt;
  logic          rpt_fire;

  // Ticks seen since the key last changed; wraps on each re-push.
  assign rpt_fire = !key_chg && is_move && frame_tick &&
                    (rpt_cnt == RW'(REPEAT_FRAMES - 1));
  assign push = is_move && (key_chg || rpt_fire);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                      rpt_cnt <= '0;
    else if (key_chg)               rpt_cnt <= '0;
    else if (is_move && frame_tick) rpt_cnt <= rpt_fire ? '0 : rpt_cnt + 1'b1;
  end
`else
  assign push = is_move && key_chg;
`endif

  always_comb begin
    case (cur_dir)
      DIR_RIGHT: hit = (px + 11'(SIZE + STEP)) > 11'(X_MAX);
      DIR_LEFT:  hit = px < 11'(X_MIN + SIZE + STEP);
      DIR_DOWN:  hit = (py + 11'(SIZE + STEP)) > 11'(Y_MAX);
      default:   hit = py < 11'(Y_MIN + SIZE + STEP);
    endcase
  end

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (push),
    .pop   (pop),
    .flush (key_flush),
    .din   (kdir),
    .dout  (head),
    .full  (fifo_full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      prev_key     <= '0;
      cur_dir      <= DIR_UP;
      frame_cnt    <= '0;
      Motion_X     <= '0;
      Motion_Y     <= '0;
      motion_valid <= 1'b0;
      busy         <= 1'b0;
      blocked      <= 1'b0;
      drop_count   <= '0;
    end else begin
      prev_key     <= keycode;
      motion_valid <= 1'b0;
      blocked      <= 1'b0;
      if (push && fifo_full && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
      if (key_flush) begin
        state    <= IDLE;
        busy     <= 1'b0;
        Motion_X <= '0;
        Motion_Y <= '0;
      end else begin
        case (state)
          IDLE: begin
            Motion_X <= '0;
            Motion_Y <= '0;
            if (!empty) begin
              state <= LOAD;
              busy  <= 1'b1;
            end
          end
          LOAD: begin
            Motion_X  <= '0;
            Motion_Y  <= '0;
            cur_dir   <= head;
            frame_cnt <= FW'(FRAMES_PER_MOVE);
            state     <= RUN;
          end
          RUN: begin
            if (frame_tick) begin
              Motion_X <= '0;
              Motion_Y <= '0;
              if (hit) begin
                blocked <= 1'b1;
                busy    <= 1'b0;
                state   <= IDLE;
              end else begin
                motion_valid <= 1'b1;
                frame_cnt    <= frame_cnt - 1'b1;
                case (cur_dir)
                  DIR_RIGHT: Motion_X <= STEP_P;
                  DIR_LEFT:  Motion_X <= STEP_N;
                  DIR_DOWN:  Motion_Y <= STEP_P;
                  default:   Motion_Y <= STEP_N;
                endcase
                if (frame_cnt == FW'(1)) begin
                  busy  <= 1'b0;
                  state <= IDLE;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
